spin_sequencer: RTL
===================

SPIN_SEQUENCER -- requirements
Module: spin_sequencer

Interface
REQ-001 Parameter MIN_SPIN_FRAMES, default 60: frame ticks from spin start to reel 1 stop, legal 1..255.
REQ-002 Parameter STAGGER_FRAMES, default 20: frame ticks between successive reel stops, legal 1..255.
REQ-003 Parameter INIT_CREDITS, default 100: total_credits value after reset, 0..4095.
REQ-004 Parameter SPIN_COST, default 1: credits deducted per accepted spin, 1..4095.
REQ-005 clk  input  1  pixel-domain clock (PLL output); all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 vsync  input  1  VGA vertical sync, same clock domain, active-low pulse.
REQ-008 spin_req  input  1  single-cycle spin request from SPI decode.
REQ-009 reel1_idx, reel2_idx, reel3_idx  input  3 each  target sprite per reel, sampled on accept.
REQ-010 is_win  input  1  win flag, sampled in PAYOUT.
REQ-011 win_credits  input  12  payout amount, sampled in PAYOUT.
REQ-012 start_spin  output  1  level, high while reels animate (to memory controller).
REQ-013 final1_sprite, final2_sprite, final3_sprite  output  3 each  latched targets.
REQ-014 reel_stop  output  3  sticky per-reel stop flags, bit0 = reel 1.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse at spin completion.
REQ-017 reject  output  1  one-cycle pulse when a request is refused for insufficient credits.
REQ-018 total_credits  output  12  running credit balance.

Function
REQ-019 Frame tick: one-cycle internal strobe on vsync 1->0 transition (registered previous vsync).
REQ-020 States: IDLE, SPIN, STOP1, STOP2, PAYOUT; one 8-bit frame counter.
REQ-021 IDLE, spin_req and total_credits >= SPIN_COST: next cycle latch reel indices into final*_sprite, total_credits -= SPIN_COST, reel_stop = 000, counter = 0, start_spin = 1, enter SPIN.
REQ-022 IDLE, spin_req and total_credits < SPIN_COST: reject pulses next cycle; all other state unchanged.
REQ-023 spin_req outside IDLE is ignored: no latch, no deduction, no reject.
REQ-024 SPIN: counter increments per tick; on tick where counter == MIN_SPIN_FRAMES-1 set reel_stop[0], clear counter, enter STOP1.
REQ-025 STOP1: on tick where counter == STAGGER_FRAMES-1 set reel_stop[1], clear counter, enter STOP2.
REQ-026 STOP2: on tick where counter == STAGGER_FRAMES-1 set reel_stop[2], clear start_spin, enter PAYOUT.
REQ-027 PAYOUT (exactly one cycle): if is_win, total_credits += win_credits saturating at 4095; done pulses next cycle; enter IDLE.
REQ-028 reel_stop and final*_sprite hold after PAYOUT until next accepted spin.
REQ-029 Total spin latency from accept to done: MIN_SPIN_FRAMES + 2*STAGGER_FRAMES ticks plus 2 cycles.
REQ-030 Counter advances only on ticks; vsync held static stalls the sequence indefinitely.

Reset
REQ-031 reset_n low, asynchronously: state IDLE, counter 0, start_spin 0, reel_stop 000, final*_sprite 0, busy 0, done 0, reject 0, total_credits INIT_CREDITS, vsync history register 1.
REQ-032 Reset mid-spin abandons the spin without refund; credits return to INIT_CREDITS.

Configuration
REQ-033 Macro SPIN_SEQ_STATE_LED_EN defined: extra output state_led [2:0] = IDLE 000, SPIN 001, STOP1 010, STOP2 011, PAYOUT 100, reset 000.
REQ-034 Macro undefined: state_led port absent; all other behaviour identical.

Verification (MIN_SPIN_FRAMES=4, STAGGER_FRAMES=2, INIT_CREDITS=3, SPIN_COST=1)
REQ-035 Reset, spin_req with idx 5/2/7 -> total_credits 2, final sprites 5/2/7, start_spin 1; reel_stop 001 at tick 4, 011 at tick 6, 111 at tick 8; done one cycle after PAYOUT.
REQ-036 is_win=1, win_credits=10 in PAYOUT -> total_credits 2 -> 12; is_win=0 -> stays 2.
REQ-037 Three spins without win, then fourth spin_req -> reject pulse, busy stays 0, total_credits 0.
REQ-038 spin_req pulsed during SPIN -> ignored; credits and sprites unchanged; exactly one done.
REQ-039 total_credits 4090, win_credits 100 -> total_credits 4095.
REQ-040 reset_n low during STOP1 -> immediate IDLE, start_spin 0, reel_stop 000, total_credits 3; with SPIN_SEQ_STATE_LED_EN, state_led 010 before reset, 000 after.

Source files
------------

// File: rtl/spin_sequencer.sv
// Slot-machine spin sequencer: paces three reel stops on VGA frame ticks and keeps the credit balance.
// Define SPIN_SEQ_STATE_LED_EN to add the state_led debug output.
module spin_sequencer #(
  parameter int MIN_SPIN_FRAMES = 60,
  parameter int STAGGER_FRAMES  = 20,
  parameter int INIT_CREDITS    = 100,
  parameter int SPIN_COST       = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vsync,
  input  logic        spin_req,
  input  logic [2:0]  reel1_idx,
  input  logic [2:0]  reel2_idx,
  input  logic [2:0]  reel3_idx,
  input  logic        is_win,
  input  logic [11:0] win_credits,
  output logic        start_spin,
  output logic [2:0]  final1_sprite,
  output logic [2:0]  final2_sprite,
  output logic [2:0]  final3_sprite,
  output logic [2:0]  reel_stop,
  output logic        busy,
  output logic        done,
  output logic        reject,
  output logic [11:0] total_credits
`ifdef SPIN_SEQ_STATE_LED_EN
  ,
  output logic [2:0]  state_led
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPIN   = 3'd1,
    STOP1  = 3'd2,
    STOP2  = 3'd3,
    PAYOUT = 3'd4
  } state_t;

  localparam logic [7:0]  MIN_LAST     = 8'(MIN_SPIN_FRAMES - 1);
  localparam logic [7:0]  STAGGER_LAST = 8'(STAGGER_FRAMES - 1);
  localparam logic [11:0] COST         = 12'(SPIN_COST);
  localparam logic [11:0] INIT         = 12'(INIT_CREDITS);

  state_t      state, state_nx;
  logic [7:0]  count, count_nx;
  logic        vsync_q;
  logic        tick;
  logic        start_spin_nx;
  logic [2:0]  reel_stop_nx;
  logic [2:0]  final1_nx, final2_nx, final3_nx;
  logic [11:0] credits_nx;
  logic        done_nx, reject_nx;
  logic [12:0] win_sum;

  // Frame tick fires on the falling edge of the active-low vsync pulse.
  assign tick    = vsync_q & ~vsync;
  assign busy    = (state != IDLE);
  assign win_sum = {1'b0, total_credits} + {1'b0, win_credits};

`ifdef SPIN_SEQ_STATE_LED_EN
  assign state_led = state;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nx      = state;
    count_nx      = count;
    start_spin_nx = start_spin;
    reel_stop_nx  = reel_stop;
    final1_nx     = final1_sprite;
    final2_nx     = final2_sprite;
    final3_nx     = final3_sprite;
    credits_nx    = total_credits;
    done_nx       = 1'b0;
    reject_nx     = 1'b0;

    unique case (state)
      IDLE: begin
        if (spin_req) begin
          if (total_credits >= COST) begin
            final1_nx     = reel1_idx;
            final2_nx     = reel2_idx;
            final3_nx     = reel3_idx;
            credits_nx    = total_credits - COST;
            reel_stop_nx  = 3'b000;
            count_nx      = 8'd0;
            start_spin_nx = 1'b1;
            state_nx      = SPIN;
          end else begin
            reject_nx = 1'b1;
          end
        end
      end
      SPIN: begin
        if (tick) begin
          if (count == MIN_LAST) begin
            reel_stop_nx[0] = 1'b1;
            count_nx        = 8'd0;
            state_nx        = STOP1;
          end else begin
            count_nx = count + 8'd1;
          end
        end
      end
      STOP1: begin
        if (tick) begin
          if (count == STAGGER_LAST) begin
            reel_stop_nx[1] = 1'b1;
            count_nx        = 8'd0;
            state_nx        = STOP2;
          end else begin
            count_nx = count + 8'd1;
          end
        end
      end
      STOP2: begin
        if (tick) begin
          if (count == STAGGER_LAST) begin
            reel_stop_nx[2] = 1'b1;
            count_nx        = 8'd0;
            start_spin_nx   = 1'b0;
            state_nx        = PAYOUT;
          end else begin
            count_nx = count + 8'd1;
          end
        end
      end
      PAYOUT: begin
        // Payout saturates at the 12-bit ceiling rather than wrapping.
        if (is_win) credits_nx = win_sum[12] ? 12'hFFF : win_sum[11:0];
        done_nx  = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      count         <= 8'd0;
      vsync_q       <= 1'b1;
      start_spin    <= 1'b0;
      reel_stop     <= 3'b000;
      final1_sprite <= 3'd0;
      final2_sprite <= 3'd0;
      final3_sprite <= 3'd0;
      total_credits <= INIT;
      done          <= 1'b0;
      reject        <= 1'b0;
    end else begin
      state         <= state_nx;
      count         <= count_nx;
      vsync_q       <= vsync;
      start_spin    <= start_spin_nx;
      reel_stop     <= reel_stop_nx;
      final1_sprite <= final1_nx;
      final2_sprite <= final2_nx;
      final3_sprite <= final3_nx;
      total_credits <= credits_nx;
      done          <= done_nx;
      reject        <= reject_nx;
    end
  end

endmodule
